// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The FSM drives the enables, mux selects and ALU controls; the datapath
// supplies the opcode (from the instruction register) and the ALU zero flag.
interface multicycle_control_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] op;
  logic           zero;
  logic           PCWre;
  logic           IRWre;
  logic           RegWre;
  logic           DataMemWr;
  logic           RegDst;
  logic           WrRegDSrc;
  logic           ExtSel;
  logic           ALUSrcB;
  logic [2:0]     ALUOp;
  logic [1:0]     PCSrc;
  logic [2:0]     state;

  // Control FSM side
  modport master (
    input  op, zero,
    output PCWre, IRWre, RegWre, DataMemWr, RegDst, WrRegDSrc,
           ExtSel, ALUSrcB, ALUOp, PCSrc, state
  );

  // Datapath side
  modport slave (
    output op, zero,
    input  PCWre, IRWre, RegWre, DataMemWr, RegDst, WrRegDSrc,
           ExtSel, ALUSrcB, ALUOp, PCSrc, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences each instruction through IF/ID/EXE/MEM/WB
// and decodes the opcode into ALU controls, write enables and mux selects.
// Outputs are combinational from state and opcode (PCSrc in EXE_BEQ also
// follows zero) and are forced to zero while RST is low, so an aborted
// instruction can never issue a partial write.
module multicycle_control #(
  parameter int OPW = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  multicycle_control_if.master bus
);

  // State encodings (visible on the debug port)
  localparam logic [2:0] S_IF      = 3'b000;
  localparam logic [2:0] S_ID      = 3'b001;
  localparam logic [2:0] S_EXE_MEM = 3'b010;
  localparam logic [2:0] S_MEM     = 3'b011;
  localparam logic [2:0] S_WB_LW   = 3'b100;
  localparam logic [2:0] S_EXE_BEQ = 3'b101;
  localparam logic [2:0] S_EXE_ALU = 3'b110;
  localparam logic [2:0] S_WB_ALU  = 3'b111;

  // Opcodes
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Instruction classes, used to pick the path out of ID
  localparam logic [2:0] CL_ALU  = 3'd0;
  localparam logic [2:0] CL_MEM  = 3'd1;
  localparam logic [2:0] CL_BEQ  = 3'd2;
  localparam logic [2:0] CL_J    = 3'd3;
  localparam logic [2:0] CL_HALT = 3'd4;
  localparam logic [2:0] CL_UNK  = 3'd5;

  // Classify an opcode into its execution path
  function automatic logic [2:0] op_class(input logic [OPW-1:0] op);
    logic [2:0] cls;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR,
      OP_AND, OP_ORI, OP_SLL, OP_SLT: cls = CL_ALU;
      OP_SW, OP_LW:                   cls = CL_MEM;
      OP_BEQ:                         cls = CL_BEQ;
      OP_J:                           cls = CL_J;
      OP_HALT:                        cls = CL_HALT;
      default:                        cls = CL_UNK;
    endcase
    return cls;
  endfunction

  // Opcode -> {ALUOp[2:0], ALUSrcB, ExtSel, RegDst}; don't-cares resolve to 0
  function automatic logic [5:0] alu_decode(input logic [OPW-1:0] op);
    logic [5:0] f;
    case (op)
      OP_ADD:  f = {3'b000, 1'b0, 1'b0, 1'b1};
      OP_SUB:  f = {3'b001, 1'b0, 1'b0, 1'b1};
      OP_ADDI: f = {3'b000, 1'b1, 1'b1, 1'b0};
      OP_OR:   f = {3'b101, 1'b0, 1'b0, 1'b1};
      OP_AND:  f = {3'b110, 1'b0, 1'b0, 1'b1};
      OP_ORI:  f = {3'b101, 1'b1, 1'b0, 1'b0};
      OP_SLL:  f = {3'b100, 1'b1, 1'b0, 1'b1};
      OP_SLT:  f = {3'b010, 1'b0, 1'b0, 1'b1};
      OP_SW:   f = {3'b000, 1'b1, 1'b1, 1'b0};
      OP_LW:   f = {3'b000, 1'b1, 1'b1, 1'b0};
      OP_BEQ:  f = {3'b001, 1'b0, 1'b1, 1'b0};
      default: f = 6'b000000;
    endcase
    return f;
  endfunction

  logic [2:0] state_r;
  logic [2:0] next_state_s;
  logic [2:0] cls_s;
  logic [5:0] alu_f_s;

  logic       pc_wre_s;
  logic       ir_wre_s;
  logic       reg_wre_s;
  logic       mem_wr_s;
  logic       reg_dst_s;
  logic       wr_src_s;
  logic       ext_sel_s;
  logic       alu_src_b_s;
  logic [2:0] alu_op_s;
  logic [1:0] pc_src_s;

  assign cls_s   = op_class(bus.op);
  assign alu_f_s = alu_decode(bus.op);

  // State register; reset parks the FSM in IF
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing through the instruction phases
  always_comb begin
    next_state_s = S_IF;
    case (state_r)
      S_IF: next_state_s = S_ID;
      S_ID: begin
        case (cls_s)
          CL_ALU:  next_state_s = S_EXE_ALU;
          CL_MEM:  next_state_s = S_EXE_MEM;
          CL_BEQ:  next_state_s = S_EXE_BEQ;
          CL_HALT: next_state_s = S_ID;
          default: next_state_s = S_IF;
        endcase
      end
      S_EXE_ALU: next_state_s = S_WB_ALU;
      S_WB_ALU:  next_state_s = S_IF;
      S_EXE_MEM: next_state_s = S_MEM;
      S_MEM: begin
        if (bus.op == OP_LW) begin
          next_state_s = S_WB_LW;
        end else begin
          next_state_s = S_IF;
        end
      end
      S_WB_LW:   next_state_s = S_IF;
      S_EXE_BEQ: next_state_s = S_IF;
      default:   next_state_s = S_IF;
    endcase
  end

  // Control decode; everything low while reset is held
  always_comb begin
    pc_wre_s    = 1'b0;
    ir_wre_s    = 1'b0;
    reg_wre_s   = 1'b0;
    mem_wr_s    = 1'b0;
    reg_dst_s   = 1'b0;
    wr_src_s    = 1'b0;
    ext_sel_s   = 1'b0;
    alu_src_b_s = 1'b0;
    alu_op_s    = 3'b000;
    pc_src_s    = 2'b00;
    if (RST) begin
      case (state_r)
        S_IF: ir_wre_s = 1'b1;
        S_ID: begin
          case (cls_s)
            CL_J: begin
              pc_wre_s = 1'b1;
              pc_src_s = 2'b10;
            end
            CL_UNK:  pc_wre_s = 1'b1;
            default: pc_wre_s = 1'b0;
          endcase
        end
        S_EXE_ALU, S_EXE_MEM: begin
          {alu_op_s, alu_src_b_s, ext_sel_s, reg_dst_s} = alu_f_s;
        end
        S_WB_ALU: begin
          {alu_op_s, alu_src_b_s, ext_sel_s, reg_dst_s} = alu_f_s;
          reg_wre_s = 1'b1;
          pc_wre_s  = 1'b1;
        end
        S_MEM: begin
          {alu_op_s, alu_src_b_s, ext_sel_s, reg_dst_s} = alu_f_s;
          if (bus.op == OP_SW) begin
            mem_wr_s = 1'b1;
            pc_wre_s = 1'b1;
          end else begin
            mem_wr_s = 1'b0;
          end
        end
        S_WB_LW: begin
          reg_wre_s = 1'b1;
          wr_src_s  = 1'b1;
          pc_wre_s  = 1'b1;
        end
        S_EXE_BEQ: begin
          {alu_op_s, alu_src_b_s, ext_sel_s, reg_dst_s} = alu_f_s;
          pc_wre_s = 1'b1;
          pc_src_s = bus.zero ? 2'b01 : 2'b00;
        end
        default: pc_wre_s = 1'b0;
      endcase
    end else begin
      pc_wre_s = 1'b0;
    end
  end

  assign bus.PCWre     = pc_wre_s;
  assign bus.IRWre     = ir_wre_s;
  assign bus.RegWre    = reg_wre_s;
  assign bus.DataMemWr = mem_wr_s;
  assign bus.RegDst    = reg_dst_s;
  assign bus.WrRegDSrc = wr_src_s;
  assign bus.ExtSel    = ext_sel_s;
  assign bus.ALUSrcB   = alu_src_b_s;
  assign bus.ALUOp     = alu_op_s;
  assign bus.PCSrc     = pc_src_s;
  assign bus.state     = RST ? state_r : 3'b000;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. The reference model describes
// each instruction as a list of per-cycle control words indexed by cycle
// number within the instruction.
module tb_multicycle_control;

  localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_HALT = 5, C_UNK = 6;

  logic CLK;
  logic RST;
  int   tests_run;
  int   tests_failed;

  multicycle_control_if #(.OPW(6)) bus ();
  multicycle_control #(.OPW(6)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed control word
  function automatic logic [15:0] obs();
    return {bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.DataMemWr, bus.RegDst,
            bus.WrRegDSrc, bus.ExtSel, bus.ALUSrcB, bus.ALUOp, bus.PCSrc};
  endfunction

  function automatic logic [15:0] pack(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic rgw, input logic dmw, input logic rdst,
                                       input logic wsrc, input logic ext, input logic srcb,
                                       input logic [2:0] aop, input logic [1:0] pcs);
    return {st, pcw, irw, rgw, dmw, rdst, wsrc, ext, srcb, aop, pcs};
  endfunction

  // Opcode table: class and ALU-side fields
  function automatic void decode(input logic [5:0] op, output int cls, output logic [2:0] aop,
                                 output logic sb, output logic ex, output logic rd);
    cls = C_ALU; aop = 3'b000; sb = 1'b0; ex = 1'b0; rd = 1'b0;
    case (op)
      6'b000000: begin aop = 3'b000; rd = 1'b1; end
      6'b000001: begin aop = 3'b001; rd = 1'b1; end
      6'b000010: begin aop = 3'b000; sb = 1'b1; ex = 1'b1; end
      6'b010000: begin aop = 3'b101; rd = 1'b1; end
      6'b010001: begin aop = 3'b110; rd = 1'b1; end
      6'b010010: begin aop = 3'b101; sb = 1'b1; end
      6'b011000: begin aop = 3'b100; sb = 1'b1; rd = 1'b1; end
      6'b100110: begin aop = 3'b010; rd = 1'b1; end
      6'b110000: begin cls = C_SW; sb = 1'b1; ex = 1'b1; end
      6'b110001: begin cls = C_LW; sb = 1'b1; ex = 1'b1; end
      6'b110100: begin cls = C_BEQ; aop = 3'b001; ex = 1'b1; end
      6'b111000: cls = C_J;
      6'b111111: cls = C_HALT;
      default:   cls = C_UNK;
    endcase
  endfunction

  function automatic int instr_len(input logic [5:0] op);
    int cls; logic [2:0] a; logic s, e, r;
    decode(op, cls, a, s, e, r);
    case (cls)
      C_ALU:   return 4;
      C_LW:    return 5;
      C_SW:    return 4;
      C_BEQ:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control word in cycle k of an instruction with opcode op
  function automatic logic [15:0] model(input logic [5:0] op, input logic z, input int k);
    int cls; logic [2:0] a; logic sb, ex, rd;
    logic [15:0] v;
    decode(op, cls, a, sb, ex, rd);
    v = 16'h0000;
    if (k == 0) begin
      v = pack(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    end else if (k == 1 || cls == C_HALT) begin
      if (cls == C_J)
        v = pack(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10);
      else if (cls == C_UNK)
        v = pack(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
      else
        v = pack(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00);
    end else begin
      case (cls)
        C_ALU: v = (k == 2) ? pack(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0, ex, sb, a, 2'b00)
                            : pack(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, rd, 1'b0, ex, sb, a, 2'b00);
        C_LW: begin
          if (k == 2)      v = pack(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0, ex, sb, a, 2'b00);
          else if (k == 3) v = pack(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0, ex, sb, a, 2'b00);
          else             v = pack(3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00);
        end
        C_SW: v = (k == 2) ? pack(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, rd, 1'b0, ex, sb, a, 2'b00)
                           : pack(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, rd, 1'b0, ex, sb, a, 2'b00);
        C_BEQ: v = pack(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, rd, 1'b0, ex, sb, a, z ? 2'b01 : 2'b00);
        default: v = 16'hffff;
      endcase
    end
    return v;
  endfunction

  task automatic test_reset();
    logic [15:0] act;
    RST = 1'b0;
    bus.op = 6'($urandom_range(0, 63));
    bus.zero = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      #1;
      act = obs();
      tests_run++;
      if (act !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, act, 16'h0000);
      end
      @(negedge CLK);
    end
    RST = 1'b1;
  endtask

  // Drive one instruction (starting on a negedge in IF) and check every cycle
  task automatic test_instr(input string name, input logic [5:0] op, input logic z);
    logic [15:0] act, exp;
    bus.op = op;
    bus.zero = z;
    for (int k = 0; k < instr_len(op); k++) begin
      #1;
      act = obs();
      exp = model(op, z, k);
      tests_run++;
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL %s op=%b k=%0d got=%h exp=%h", name, op, k, act, exp);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_add();
    test_instr("add", 6'b000000, 1'b0);
  endtask

  task automatic test_lw();
    test_instr("lw", 6'b110001, 1'b1);
  endtask

  task automatic test_beq();
    test_instr("beq_taken", 6'b110100, 1'b1);
    test_instr("beq_not_taken", 6'b110100, 1'b0);
  endtask

  task automatic test_j_unknown();
    test_instr("jump", 6'b111000, 1'b0);
    test_instr("unknown", 6'b101010, 1'b1);
  endtask

  task automatic test_halt_reset();
    logic [15:0] act, exp;
    bus.op = 6'b111111;
    bus.zero = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      #1;
      act = obs();
      exp = model(6'b111111, 1'b0, k);
      tests_run++;
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL halt k=%0d got=%h exp=%h", k, act, exp);
      end
      @(negedge CLK);
    end
    #2;
    RST = 1'b0;
    #1;
    act = obs();
    tests_run++;
    if (act !== 16'h0000) begin
      tests_failed++;
      $display("FAIL halt_async_reset got=%h exp=%h", act, 16'h0000);
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_sw_abort();
    logic [15:0] act, exp;
    bus.op = 6'b110000;
    bus.zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      act = obs();
      exp = model(6'b110000, 1'b0, k);
      tests_run++;
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL sw_pre_abort k=%0d got=%h exp=%h", k, act, exp);
      end
      if (k < 2) @(negedge CLK);
    end
    #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      act = obs();
      tests_run++;
      if (act !== 16'h0000) begin
        tests_failed++;
        $display("FAIL sw_abort cyc=%0d got=%h exp=%h", i, act, 16'h0000);
      end
      @(negedge CLK);
    end
    RST = 1'b1;
    test_instr("sw_after_abort", 6'b110000, 1'b1);
  endtask

  function automatic logic [5:0] pick_op(input int idx);
    logic [5:0] op;
    case (idx)
      0:  op = 6'b000000;
      1:  op = 6'b000001;
      2:  op = 6'b000010;
      3:  op = 6'b010000;
      4:  op = 6'b010001;
      5:  op = 6'b010010;
      6:  op = 6'b011000;
      7:  op = 6'b100110;
      8:  op = 6'b110000;
      9:  op = 6'b110001;
      10: op = 6'b110100;
      11: op = 6'b111000;
      default: begin
        op = 6'($urandom_range(0, 63));
        if (op == 6'b111111) op = 6'b101010;
      end
    endcase
    return op;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      test_instr("random", pick_op(int'($urandom_range(0, 13))), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    RST = 1'b0;
    bus.op = 6'b000000;
    bus.zero = 1'b0;
    @(negedge CLK);
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_j_unknown();
    test_halt_reset();
    test_sw_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle control FSM that sequences each instruction through IF/ID/EXE/MEM/WB. It drives ALUOp/ALUSrcB into the ALU and write enables and mux selects into the rest of the datapath. It consumes the ALU's zero flag for branch resolution, so it is the producer side of the ALU control interface. Opcode comes from the instruction register, which holds stable from the end of IF until the next IF.

Parameters:
OPW, 6, opcode width; the encodings below are fixed for this width.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
op  input  6  opcode from the instruction register
zero  input  1  ALU zero flag; valid in EXE_BEQ
PCWre  output  1  PC load enable
IRWre  output  1  instruction register load enable
RegWre  output  1  register file write enable
DataMemWr  output  1  data memory write enable
RegDst  output  1  destination select: 1=rd, 0=rt
WrRegDSrc  output  1  writeback source: 0=ALU result, 1=memory data
ExtSel  output  1  immediate extend: 1=sign, 0=zero
ALUSrcB  output  1  ALU B operand: 1=Extend, 0=BDR
ALUOp  output  3  ALU operation code
PCSrc  output  2  next PC: 00=PC+4, 01=PC+4+(imm<<2), 10=jump target
state  output  3  current state, for debug

Behaviour:
- Reset: RST low asynchronously forces state=IF. While RST is low, every output is 0, including IRWre, PCWre and ALUOp. After release, the first rising edge leaves IF.
- State encodings: IF=000, ID=001, EXE_MEM=010, MEM=011, WB_LW=100, EXE_BEQ=101, EXE_ALU=110, WB_ALU=111.
- Opcode map (op -> ALUOp, ALUSrcB, ExtSel, RegDst):
  - add 000000 -> 000, 0, -, 1
  - sub 000001 -> 001, 0, -, 1
  - addi 000010 -> 000, 1, 1, 0
  - or 010000 -> 101, 0, -, 1
  - and 010001 -> 110, 0, -, 1
  - ori 010010 -> 101, 1, 0, 0
  - sll 011000 -> 100, 1, 0, 1
  - slt 100110 -> 010, 0, -, 1
  - sw 110000 -> 000, 1, 1, -
  - lw 110001 -> 000, 1, 1, 0
  - beq 110100 -> 001, 0, 1, -
  - j 111000
  - halt 111111
  - any other opcode is "unknown".
- Transitions:
  - IF -> ID.
  - ID -> EXE_ALU for add/sub/addi/or/and/ori/sll/slt; EXE_MEM for sw/lw; EXE_BEQ for beq; IF for j and unknown; ID (self-loop) for halt.
  - EXE_ALU -> WB_ALU -> IF.
  - EXE_MEM -> MEM. MEM -> IF for sw; MEM -> WB_LW for lw. WB_LW -> IF.
  - EXE_BEQ -> IF.
- Outputs are combinational from state and op. Only PCSrc in EXE_BEQ also depends on zero.
  - IF: IRWre=1; all other enables 0.
  - ID, opcode j: PCWre=1, PCSrc=10.
  - ID, unknown opcode: PCWre=1, PCSrc=00 (executes as a nop).
  - ID, halt: all enables 0; stays in ID until reset.
  - EXE_ALU, EXE_MEM, EXE_BEQ: ALUOp, ALUSrcB, ExtSel per the opcode map.
  - WB_ALU: RegWre=1, WrRegDSrc=0, PCWre=1, PCSrc=00. ALU controls stay held at EXE values.
  - MEM: ALU controls held. For sw: DataMemWr=1, PCWre=1, PCSrc=00. For lw: no enables.
  - WB_LW: RegWre=1, WrRegDSrc=1, RegDst=0, PCWre=1, PCSrc=00.
  - EXE_BEQ: PCWre=1; PCSrc=01 if zero=1, else 00.
- Invariants:
  - In any state not listed above: ALUOp=000, ALUSrcB=0, ExtSel=0, RegDst=0, WrRegDSrc=0.
  - PCWre is high exactly once per instruction, in its final state.
  - RegWre and DataMemWr are never high together.
- Cycle counts per instruction: ALU 4, lw 5, sw 4, beq 3, j 2, unknown 2.
- RST asserted mid-instruction aborts it immediately. No partial write is issued after reset assertion.

Test Plan:
- Reset release, op=000000 (add), zero=0 -> states 000,001,110,111,000. In 111: RegWre=1, PCWre=1, RegDst=1, ALUOp=000.
- op=110001 (lw) -> 000,001,010,011,100,000. In 100: RegWre=1, WrRegDSrc=1. DataMemWr never 1. ALUSrcB=1, ExtSel=1 in states 010 and 011.
- op=110100 (beq), run twice: zero=1 in 101 gives PCSrc=01; zero=0 gives PCSrc=00. PCWre=1 in 101 both times; 3 cycles each.
- op=111000 (j) -> 000,001,000 with PCSrc=10, PCWre=1 in 001. op=101010 (unknown) -> same path, PCSrc=00.
- op=111111 (halt) -> stays at 001 for 20 cycles with all enables 0. RST low -> state 000 asynchronously, before any clock edge.
- op=110000 (sw): assert RST low while state=010 -> state=000 and all outputs 0 immediately. DataMemWr is never asserted. After release, a fresh sw completes in 4 cycles with DataMemWr=1 only in 011.
